// File: rtl/op_amp_array.sv
// op_amp_array: multi-channel op-amp model; offset/diff, fixed-point gain, rail clamp and slew limit.
module op_amp_array #(
  parameter int WIDTH = 16,
  parameter int CHANNELS = 2,
  parameter int GAIN_W = 8,
  parameter int FRAC = 4,
  parameter int SLEW_W = 12,
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [CHANNELS*WIDTH-1:0]    vin_p,
  input  logic [CHANNELS*WIDTH-1:0]    vin_n,
  input  logic signed [WIDTH-1:0]      vcc,
  input  logic signed [WIDTH-1:0]      vee,
  input  logic                         cfg_we,
  input  logic [CW-1:0]                cfg_ch,
  input  logic [1:0]                   cfg_mode,
  input  logic [GAIN_W-1:0]            cfg_gain,
  input  logic signed [WIDTH-1:0]      cfg_offset,
  input  logic [SLEW_W-1:0]            cfg_slew,
  output logic                         out_valid,
  output logic [CHANNELS*WIDTH-1:0]    vout,
  output logic [CHANNELS-1:0]          sat_hi,
  output logic [CHANNELS-1:0]          sat_lo
);
  localparam int DW = WIDTH + 2;
  localparam int PW = DW + GAIN_W;
  logic v1, v2, v3, bad_rails;
  assign bad_rails = vee > vcc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {v1, v2, v3, out_valid} <= '0;
    else {v1, v2, v3, out_valid} <= {in_valid, v1, v2, v3};
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [1:0] mode, m1, m2;
    logic [GAIN_W-1:0] gain, g1;
    logic signed [WIDTH-1:0] offset, vp, vn, tc, t3, vo, tgt, nxt;
    logic [SLEW_W-1:0] slew, s1, s2, s3;
    logic signed [DW-1:0] dm, d, d1;
    logic signed [PW-1:0] prod, p, p2;
    logic signed [WIDTH:0] diff;
    logic [WIDTH:0] mag;
    logic cmp, pos, hi, lo, hold, shi, slo, h3, hi3, lo3, hi_o, lo_o;
    assign vp = vin_p[c*WIDTH +: WIDTH];
    assign vn = vin_n[c*WIDTH +: WIDTH];
    assign vout[c*WIDTH +: WIDTH] = vo;
    assign sat_hi[c] = hi_o;
    assign sat_lo[c] = lo_o;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        mode <= '0;
        gain <= GAIN_W'(1 << FRAC);
        offset <= '0;
        slew <= '0;
      end else if (cfg_we && cfg_ch == CW'(c)) begin
        mode <= cfg_mode;
        gain <= cfg_gain;
        offset <= cfg_offset;
        slew <= cfg_slew;
      end
    always_comb begin
      dm = mode == 2'b01 ? DW'(vp) + DW'(offset) : DW'(vp) - DW'(vn) + DW'(offset);
      d = mode == 2'b11 ? -dm : dm;
      prod = d1 * $signed({1'b0, g1});
      p = m1 == 2'b10 ? PW'(d1) : prod >>> FRAC;
      cmp = m2 == 2'b10;
      pos = !p2[PW-1] && |p2;
      hi = p2 > PW'(vcc);
      lo = p2 < PW'(vee);
      hold = !bad_rails && cmp && p2 == '0;
      tc = bad_rails ? '0 : cmp ? (pos ? vcc : vee) : hi ? vcc : lo ? vee : p2[WIDTH-1:0];
      shi = bad_rails | (!hold & hi);
      slo = bad_rails | (!hold & lo);
      tgt = h3 ? vo : t3;
      diff = (WIDTH+1)'(tgt) - (WIDTH+1)'(vo);
      mag = diff[WIDTH] ? -diff : diff;
      nxt = s3 == '0 || mag <= (WIDTH+1)'(s3) ? tgt : diff[WIDTH] ? vo - WIDTH'(s3) : vo + WIDTH'(s3);
    end
    // Comparator hold resolves against the live vout at the final edge, like slew does
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        {d1, m1, g1, s1} <= '0;
        {p2, m2, s2} <= '0;
        {t3, h3, hi3, lo3, s3} <= '0;
        {vo, hi_o, lo_o} <= '0;
      end else begin
        if (in_valid) {d1, m1, g1, s1} <= {d, mode, gain, slew};
        if (v1) {p2, m2, s2} <= {p, m1, s1};
        if (v2) {t3, h3, hi3, lo3, s3} <= {tc, hold, shi, slo, s2};
        if (v3) {vo, hi_o, lo_o} <= {nxt, hi3, lo3};
      end
  end
endmodule

// File: tb/tb_op_amp_array.sv
// tb_op_amp_array: directed plan plus randomized traffic against a sample-level reference model.
module tb_op_amp_array;
  logic clk = 0, rst_n = 0, in_valid = 0, cfg_we = 0, out_valid;
  logic [31:0] vin_p = 0, vin_n = 0, vout;
  logic signed [15:0] vcc = 16'sd5000, vee = -16'sd5000, cfg_offset = 0;
  logic cfg_ch = 0;
  logic [1:0] cfg_mode = 0, sat_hi, sat_lo;
  logic [7:0] cfg_gain = 8'd16;
  logic [11:0] cfg_slew = 0;

  always #5 clk = ~clk;

  op_amp_array dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .vin_p(vin_p), .vin_n(vin_n),
    .vcc(vcc), .vee(vee), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_gain(cfg_gain), .cfg_offset(cfg_offset), .cfg_slew(cfg_slew),
    .out_valid(out_valid), .vout(vout), .sat_hi(sat_hi), .sat_lo(sat_lo)
  );

  typedef struct packed {
    int due;
    logic [1:0][31:0] v;
    logic [1:0] hi;
    logic [1:0] lo;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int mmode[2], mgain[2], moff[2], mslew[2], mv[2], sv[2];
  logic [1:0] shi = 0, slo = 0;
  int exp3[8] = '{100, 200, 300, 400, 500, 550, 550, 550};

  task automatic chk(string tag, int got, int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      mmode[c] = 0; mgain[c] = 16; moff[c] = 0; mslew[c] = 0; mv[c] = 0; sv[c] = 0;
    end
    shi = 0; slo = 0;
    q.delete();
  endtask

  // One sample through one channel, straight from the amplifier rules; returns {sat_hi, sat_lo}
  function automatic logic [1:0] model_ch(int c, int vp, int vn);
    int d, t, hv, lv;
    longint pr, p;
    logic h, l;
    hv = vcc; lv = vee;
    d = (mmode[c] == 1) ? vp + moff[c] : vp - vn + moff[c];
    if (mmode[c] == 3) d = -d;
    if (mmode[c] == 2) p = d;
    else begin
      pr = longint'(d) * mgain[c];
      p = (pr >= 0) ? pr / 16 : -((-pr + 15) / 16);
    end
    h = p > hv; l = p < lv;
    t = h ? hv : l ? lv : int'(p);
    if (mmode[c] == 2) begin
      if (d > 0) t = hv;
      else if (d < 0) t = lv;
      else begin t = mv[c]; h = 0; l = 0; end
    end
    if (lv > hv) begin t = 0; h = 1; l = 1; end
    if (mslew[c] == 0 || (t - mv[c] <= mslew[c] && mv[c] - t <= mslew[c])) mv[c] = t;
    else mv[c] = mv[c] + ((t > mv[c]) ? mslew[c] : -mslew[c]);
    return {h, l};
  endfunction

  task automatic step();
    exp_t e;
    logic [1:0] f;
    logic ev;
    @(posedge clk);
    if (rst_n) begin
      cyc++;
      if (in_valid) begin
        e.due = cyc + 3;
        for (int c = 0; c < 2; c++) begin
          f = model_ch(c, $signed(vin_p[c*16 +: 16]), $signed(vin_n[c*16 +: 16]));
          e.v[c] = mv[c]; e.hi[c] = f[1]; e.lo[c] = f[0];
        end
        q.push_back(e);
      end
      if (cfg_we) begin
        mmode[cfg_ch] = cfg_mode; mgain[cfg_ch] = cfg_gain;
        moff[cfg_ch] = cfg_offset; mslew[cfg_ch] = cfg_slew;
      end
    end
    @(negedge clk);
    ev = q.size() > 0 && q[0].due == cyc;
    chk("out_valid", int'(out_valid), int'(ev));
    if (ev) begin
      e = q.pop_front();
      for (int c = 0; c < 2; c++) sv[c] = e.v[c];
      shi = e.hi; slo = e.lo;
    end
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("vout%0d", c), $signed(vout[c*16 +: 16]), sv[c]);
      chk($sformatf("sat_hi%0d", c), int'(sat_hi[c]), int'(shi[c]));
      chk($sformatf("sat_lo%0d", c), int'(sat_lo[c]), int'(slo[c]));
    end
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic send(int p0, int n0, int p1, int n1);
    vin_p = {16'(p1), 16'(p0)};
    vin_n = {16'(n1), 16'(n0)};
    in_valid = 1;
    step();
    in_valid = 0;
  endtask

  task automatic wr(int ch, int mode, int gain, int off, int slew);
    cfg_we = 1; cfg_ch = ch[0]; cfg_mode = 2'(mode); cfg_gain = 8'(gain);
    cfg_offset = 16'(off); cfg_slew = 12'(slew);
    step();
    cfg_we = 0;
  endtask

  function automatic int rnd_sig();
    return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535)) - 32768
                                       : int'($urandom_range(0, 4000)) - 2000;
  endfunction

  initial begin
    model_reset();
    idle(2);
    chk("rst_vout0", $signed(vout[15:0]), 0);
    rst_n = 1;
    idle(1);
    // basic diff, three-cycle latency
    send(100, 40, 0, 0);
    idle(2);
    chk("t1_early", int'(out_valid), 0);
    idle(1);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_vout0", $signed(vout[15:0]), 60);
    chk("t1_flags", int'({sat_hi[0], sat_lo[0]}), 0);
    // gain x8 on ch1 saturates at vcc
    wr(1, 0, 128, 0, 0);
    send(1000, 0, 1000, 0);
    idle(3);
    chk("t2_vout1", $signed(vout[31:16]), 5000);
    chk("t2_sathi1", int'(sat_hi[1]), 1);
    chk("t2_vout0", $signed(vout[15:0]), 1000);
    chk("t2_sathi0", int'(sat_hi[0]), 0);
    // slew ramp toward 550
    send(0, 0, 0, 0);
    idle(3);
    wr(0, 0, 16, 0, 100);
    vin_p = {16'd0, 16'd550}; vin_n = 0;
    for (int i = 0; i < 11; i++) begin
      in_valid = (i < 8);
      step();
      if (i >= 3) chk($sformatf("t3_ramp%0d", i - 3), $signed(vout[15:0]), exp3[i-3]);
    end
    in_valid = 0;
    // comparator with hold on zero
    vcc = 16'sd3000; vee = -16'sd3000;
    wr(0, 2, 16, 0, 0);
    send(1, 0, 1, 0);
    idle(3);
    chk("t4_pos", $signed(vout[15:0]), 3000);
    send(0, 1, 0, 1);
    idle(3);
    chk("t4_neg", $signed(vout[15:0]), -3000);
    send(0, 0, 0, 0);
    idle(3);
    chk("t4_hold", $signed(vout[15:0]), -3000);
    chk("t4_flags", int'({sat_hi[0], sat_lo[0]}), 0);
    // offset trim, inverting, illegal rails
    wr(0, 0, 16, -5, 0);
    send(0, 0, 0, 0);
    idle(3);
    chk("t5_off", $signed(vout[15:0]), -5);
    wr(0, 3, 16, -5, 0);
    send(0, 0, 0, 0);
    idle(3);
    chk("t5_inv", $signed(vout[15:0]), 5);
    vcc = -16'sd10; vee = 16'sd10;
    send(0, 0, 0, 0);
    idle(3);
    chk("t5_bad", $signed(vout[15:0]), 0);
    chk("t5_badflags", int'({sat_hi[0], sat_lo[0]}), 3);
    vcc = 16'sd5000; vee = -16'sd5000;
    send(700, 0, 300, 0);
    idle(3);
    // asynchronous reset with two samples in flight
    send(100, 0, 100, 0);
    send(200, 0, 200, 0);
    rst_n = 0;
    #1;
    chk("t6_vout", int'(vout), 0);
    chk("t6_valid", int'(out_valid), 0);
    model_reset();
    idle(2);
    @(negedge clk);
    rst_n = 1;
    idle(5);
    send(100, 0, 100, 0);
    idle(3);
    chk("t6_unity1", $signed(vout[31:16]), 100);
    chk("t6_mode0", $signed(vout[15:0]), 100);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        in_valid = 0; cfg_we = 0;
        idle(3);
        vcc = 16'($urandom_range(0, 20000));
        vee = -16'($urandom_range(0, 20000));
        if ($urandom_range(0, 7) == 0) begin vcc = -16'sd50; vee = 16'sd50; end
      end
      vin_p = {16'(rnd_sig()), 16'(rnd_sig())};
      vin_n = {16'(rnd_sig()), 16'(rnd_sig())};
      in_valid = $urandom_range(0, 3) != 0;
      cfg_we = $urandom_range(0, 5) == 0;
      cfg_ch = 1'($urandom_range(0, 1));
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_gain = 8'($urandom_range(0, 255));
      cfg_offset = 16'($urandom_range(0, 400)) - 16'sd200;
      cfg_slew = ($urandom_range(0, 2) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
      step();
    end
    in_valid = 0; cfg_we = 0;
    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
